mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Sequences the shared single-port unified instruction/data memory between two requesters: instruction fetch (IF) and the load/store stage (MEM). It replaces the ad-hoc "stall fetch on write" rule with an explicit request/done handshake, data-first priority with a starvation guard, fixed-latency access timing, and per-requester stall requests to ctrl.v. It sits between pc_reg/if_id, mem.v and the memory array.

Parameters:
MEM_LAT, 2, memory read/write latency in cycles (legal 1..15)
STARVE_MAX, 3, max consecutive data grants while a fetch is pending
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch address
if_done  out  1  one-cycle pulse: if_inst valid
if_inst  out  32  fetched instruction
if_err  out  1  with if_done: misaligned fetch
if_stall_req  out  1  to ctrl.v
d_req  in  1  data request, held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  32  store data, right-justified
d_valid_bit  in  2  Byte/Half/Word
d_done  out  1  one-cycle pulse: access complete
d_rdata  out  32  load data, zero-extended, right-justified
d_err  out  1  with d_done: misaligned access
d_stall_req  out  1  to ctrl.v
mem_ce  out  1  memory chip enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  byte address, driven unmodified
mem_valid_bit  out  2  access size
mem_wdata  out  32  write data
mem_rdata  in  32  word at {mem_addr[31:2],2'b00}, valid MEM_LAT cycles after mem_ce rises

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; starve_cnt 0; lat_cnt 0. Reset mid-access drops the access. mem_ce falls without waiting for a clock.
- States:
  - IDLE: arbitrate.
  - ACCESS: memory busy, lat_cnt counts down.
  - RESP: one cycle; done, data and err are valid.
- IDLE grant rules:
  - d_req wins unless if_req && starve_cnt==STARVE_MAX.
  - Otherwise if_req wins.
  - No request: remain in IDLE.
- starve_cnt:
  - Increments on a data grant while if_req=1.
  - Clears on any IF grant, or on any cycle with if_req=0.
  - Saturates at STARVE_MAX.
- Alignment check at grant:
  - Fetch: error if addr[1:0]!=0.
  - Half: error if addr[0]=1.
  - Word: error if addr[1:0]!=0.
  - Byte: never an error.
  - Misaligned: go directly to RESP with err=1, no memory cycle, rdata=0.
- Aligned grant: latch owner, addr, we, size and wdata; go to ACCESS with lat_cnt=MEM_LAT-1. mem_* outputs are registered and asserted for exactly MEM_LAT cycles. mem_we=1 only for data stores.
- At the ACCESS edge where lat_cnt==0:
  - Capture mem_rdata.
  - Loads: lane-extract by addr[1:0] and zero-extend. Byte = rdata[8*a+7:8*a]; Half = rdata[16*a[1]+15:16*a[1]].
  - Stores: return rdata=0.
  - Go to RESP.
- RESP: pulse the owner's done (and err) for one cycle, then return to IDLE. The next grant is possible in the cycle after RESP.
- Latency: request sampled in IDLE at cycle t means done is high in cycle t+MEM_LAT+1. Throughput is one access per MEM_LAT+2 cycles.
- if_inst and d_rdata hold their value until the next response to the same requester.
- Stall outputs: if_stall_req = if_req & ~if_done; d_stall_req = d_req & ~d_done (combinational).
- Request dropped mid-access (flush): the access completes and done still pulses. A store is never aborted.
- Simultaneous requests at the first cycle out of reset: data wins (starve_cnt=0).
- Illegal d_valid_bit (2'b00): treated as an error, d_err=1, no access.

Decomposition:
- Shared package (defs.v): `Byte=2'b01, `Half=2'b10, `Word=2'b11; arbiter state encodings (ArbIdle, ArbAccess, ArbResp); owner encodings (OwnerIF, OwnerD).
- One natural sub-module, mem_lane_extract: combinational lane select and zero-extend from (rdata, addr[1:0], size).

Test Plan:
- MEM_LAT=2; if_req alone, addr 0x10, mem word 0x00C00093 -> if_done in cycle t+3, if_inst=0x00C00093, mem_ce high exactly 2 cycles.
- d_req load Byte at 0x13, word 0xAABBCCDD -> d_rdata=0x000000AA; Half at 0x12 -> 0x0000AABB.
- if_req and d_req both held continuously, STARVE_MAX=3 -> grant order D,D,D,IF,D,D,D,IF; if_stall_req high throughout each wait.
- Store Word 0x12345678 at 0x20 -> mem_we=1 for 2 cycles, mem_wdata=0x12345678; then fetch 0x20 returns 0x12345678.
- Word load at 0x22 -> d_done and d_err both high in cycle t+1, mem_ce stays 0; fetch at 0x06 -> if_err=1.
- rst pulled low during ACCESS between clock edges -> mem_ce=0 and state IDLE immediately; after release, a pending if_req is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory arbiter: access sizes, FSM states,
// owner encoding and the alignment rule applied at grant time.
package mem_arbiter_pkg;

    localparam logic [1:0] SIZE_BAD  = 2'b00;
    localparam logic [1:0] SIZE_BYTE = 2'b01;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_D  = 1'b1
    } owner_e;

    // An illegal size is reported the same way as a misaligned address.
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_lane_extract.sv
// Selects the addressed byte/half from a memory word and zero-extends it
// into a right-justified 32-bit result.
module mem_arbiter_lane_extract
    import mem_arbiter_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SIZE_BYTE: data = {24'h0, byte_sel};
            SIZE_HALF: data = {16'h0, half_sel};
            default:   data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared single-port memory between instruction fetch and the
// load/store stage: data-first priority, starvation guard, fixed-latency access.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    output logic              if_err,
    output logic              if_stall_req,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_valid_bit,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              d_stall_req,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_valid_bit,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic              mem_ce_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [1:0]        mem_valid_bit_d;
    logic [31:0]       mem_wdata_d;
    logic              if_done_d, if_err_d, d_done_d, d_err_d;
    logic [31:0]       if_inst_d, d_rdata_d;
    logic              grant_data, grant_fetch, grant_err;
    logic [31:0]       lane_data;

    mem_arbiter_lane_extract u_lane (
        .rdata   (mem_rdata),
        .addr_lo (mem_addr[1:0]),
        .size    (mem_valid_bit),
        .data    (lane_data)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d         = state_q;
        owner_d         = owner_q;
        lat_cnt_d       = lat_cnt_q;
        starve_cnt_d    = starve_cnt_q;
        mem_ce_d        = mem_ce;
        mem_we_d        = mem_we;
        mem_addr_d      = mem_addr;
        mem_valid_bit_d = mem_valid_bit;
        mem_wdata_d     = mem_wdata;
        if_done_d       = 1'b0;
        if_err_d        = 1'b0;
        d_done_d        = 1'b0;
        d_err_d         = 1'b0;
        if_inst_d       = if_inst;
        d_rdata_d       = d_rdata;
        grant_data      = 1'b0;
        grant_fetch     = 1'b0;
        grant_err       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                grant_data  = d_req && !(if_req && starve_cnt_q == STARVE_LIM);
                grant_fetch = if_req && !grant_data;
                if (grant_data) begin
                    owner_d         = OWNER_D;
                    mem_addr_d      = d_addr;
                    mem_valid_bit_d = d_valid_bit;
                    mem_wdata_d     = d_wdata;
                    grant_err       = misaligned(d_addr[1:0], d_valid_bit);
                    mem_we_d        = d_we && !grant_err;
                    if (if_req && starve_cnt_q != STARVE_LIM)
                        starve_cnt_d = starve_cnt_q + 8'd1;
                end else if (grant_fetch) begin
                    owner_d         = OWNER_IF;
                    mem_addr_d      = if_addr;
                    mem_valid_bit_d = SIZE_WORD;
                    mem_wdata_d     = '0;
                    grant_err       = misaligned(if_addr[1:0], SIZE_WORD);
                    mem_we_d        = 1'b0;
                    starve_cnt_d    = '0;
                end

                if (grant_data || grant_fetch) begin
                    if (grant_err) begin
                        // Rejected accesses skip the memory and answer next cycle.
                        state_d = ARB_RESP;
                        if (grant_data) begin
                            d_done_d  = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = '0;
                        end else begin
                            if_done_d = 1'b1;
                            if_err_d  = 1'b1;
                            if_inst_d = '0;
                        end
                    end else begin
                        state_d   = ARB_ACCESS;
                        lat_cnt_d = LAT_INIT;
                        mem_ce_d  = 1'b1;
                    end
                end
            end

            ARB_ACCESS: begin
                if (lat_cnt_q == 4'd0) begin
                    mem_ce_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = ARB_RESP;
                    if (owner_q == OWNER_D) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = mem_we ? 32'h0 : lane_data;
                    end else begin
                        if_done_d = 1'b1;
                        if_inst_d = lane_data;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end

            ARB_RESP: state_d = ARB_IDLE;

            default:  state_d = ARB_IDLE;
        endcase

        if (!if_req)
            starve_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ARB_IDLE;
            owner_q       <= OWNER_IF;
            lat_cnt_q     <= '0;
            starve_cnt_q  <= '0;
            mem_ce        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_valid_bit <= '0;
            mem_wdata     <= '0;
            if_done       <= 1'b0;
            if_err        <= 1'b0;
            if_inst       <= '0;
            d_done        <= 1'b0;
            d_err         <= 1'b0;
            d_rdata       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q       <= state_d;
            owner_q       <= owner_d;
            lat_cnt_q     <= lat_cnt_d;
            starve_cnt_q  <= starve_cnt_d;
            mem_ce        <= mem_ce_d;
            mem_we        <= mem_we_d;
            mem_addr      <= mem_addr_d;
            mem_valid_bit <= mem_valid_bit_d;
            mem_wdata     <= mem_wdata_d;
            if_done       <= if_done_d;
            if_err        <= if_err_d;
            if_inst       <= if_inst_d;
            d_done        <= d_done_d;
            d_err         <= d_err_d;
            d_rdata       <= d_rdata_d;
        end
    end

    // Held in reset so ctrl sees no stall while the arbiter is being cleared.
    assign if_stall_req = rst & if_req & ~if_done;
    assign d_stall_req  = rst & d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: cycle-indexed transaction model plus
// directed scenarios and randomized requester traffic.
module tb_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;
    localparam int MAXC       = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done, if_err, if_stall_req;
    logic [31:0] if_inst;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [1:0]  d_valid_bit = 2'b11;
    logic        d_done, d_err, d_stall_req;
    logic [31:0] d_rdata;
    logic        mem_ce, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_valid_bit;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .if_err(if_err), .if_stall_req(if_stall_req),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_valid_bit(d_valid_bit), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .d_stall_req(d_stall_req),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_valid_bit(mem_valid_bit),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Physical memory seen by the DUT, and the model's own copy.
    logic [31:0] phys    [64];
    logic [31:0] mdl_mem [64];
    assign mem_rdata = mem_ce ? phys[mem_addr[7:2]] : 32'hDEAD_BEEF;

    // Expected behaviour, indexed by cycle number.
    bit          exp_ifd [MAXC];
    bit          exp_dd  [MAXC];
    bit          exp_er  [MAXC];
    bit          exp_ce  [MAXC];
    bit          exp_we  [MAXC];
    logic [31:0] exp_data  [MAXC];
    logic [31:0] exp_addr  [MAXC];
    logic [31:0] exp_wdata [MAXC];
    logic [1:0]  exp_vb    [MAXC];

    int          cyc = 0;
    int          free_at = 0;
    int          starve = 0;
    logic [31:0] mdl_if_inst = '0, mdl_d_rdata = '0;

    int n_checks = 0, n_pass = 0;
    int ce_cnt = 0, we_cnt = 0;
    bit cont_mode = 0, rand_mode = 0, rec_order = 0;
    int order [$];
    int exp_order [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

    bit          seen_if_done, seen_d_done, seen_if_err, seen_d_err;
    logic [31:0] seen_if_inst, seen_d_rdata, seen_wdata;
    int          seen_cyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] a,
                                          input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (size)
            2'b01:   r[int'(a) * 8 +: 8] = wd[7:0];
            2'b10:   r[int'(a[1]) * 16 +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] size);
        case (size)
            2'b01:   return (w >> (8 * int'(a))) & 32'hFF;
            2'b10:   return (w >> (16 * int'(a[1]))) & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic bit bad_access(input logic [1:0] a, input logic [1:0] size);
        return (size == 2'b00) || (size == 2'b10 && a[0]) || (size == 2'b11 && a != 2'b00);
    endfunction

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            exp_ifd[i] = 0; exp_dd[i] = 0; exp_er[i] = 0; exp_ce[i] = 0; exp_we[i] = 0;
            exp_data[i] = '0; exp_addr[i] = '0; exp_wdata[i] = '0; exp_vb[i] = '0;
        end
    endtask

    task automatic schedule(input bit is_if, input bit err, input bit we, input logic [31:0] a,
                            input logic [1:0] vb, input logic [31:0] wd, input logic [31:0] data);
        int r;
        if (err) begin
            r = cyc + 1;
            free_at = cyc + 2;
        end else begin
            for (int k = 1; k <= MEM_LAT; k++) begin
                exp_ce[cyc + k] = 1; exp_we[cyc + k] = we; exp_addr[cyc + k] = a;
                exp_vb[cyc + k] = vb; exp_wdata[cyc + k] = wd;
            end
            r = cyc + MEM_LAT + 1;
            free_at = cyc + MEM_LAT + 2;
        end
        if (is_if) exp_ifd[r] = 1; else exp_dd[r] = 1;
        exp_er[r] = err;
        exp_data[r] = data;
    endtask

    // Transaction-level arbiter: a busy timer, a starvation counter and the grant rule.
    task automatic model_step();
        bit          d_win, err;
        logic [31:0] data;
        if (cyc >= free_at && (if_req || d_req)) begin
            d_win = d_req && !(if_req && starve == STARVE_MAX);
            if (d_win) begin
                err  = bad_access(d_addr[1:0], d_valid_bit);
                data = (err || d_we) ? 32'h0 : extract(mdl_mem[d_addr[7:2]], d_addr[1:0], d_valid_bit);
                schedule(0, err, d_we, d_addr, d_valid_bit, d_wdata, data);
                if (!err && d_we)
                    mdl_mem[d_addr[7:2]] = merge(mdl_mem[d_addr[7:2]], d_addr[1:0], d_valid_bit, d_wdata);
                if (if_req && starve < STARVE_MAX) starve++;
            end else begin
                err  = if_addr[1:0] != 2'b00;
                data = err ? 32'h0 : mdl_mem[if_addr[7:2]];
                schedule(1, err, 0, if_addr, 2'b11, 32'h0, data);
                starve = 0;
            end
        end
        if (!if_req) starve = 0;
    endtask

    task automatic compare();
        if (exp_ifd[cyc]) mdl_if_inst = exp_data[cyc];
        if (exp_dd[cyc])  mdl_d_rdata = exp_data[cyc];
        check("if_done", 32'(if_done), 32'(exp_ifd[cyc]));
        check("if_err",  32'(if_err),  32'(exp_ifd[cyc] & exp_er[cyc]));
        check("d_done",  32'(d_done),  32'(exp_dd[cyc]));
        check("d_err",   32'(d_err),   32'(exp_dd[cyc] & exp_er[cyc]));
        check("if_inst", if_inst, mdl_if_inst);
        check("d_rdata", d_rdata, mdl_d_rdata);
        check("mem_ce",  32'(mem_ce), 32'(exp_ce[cyc]));
        check("mem_we",  32'(mem_we), 32'(exp_we[cyc]));
        if (exp_ce[cyc]) begin
            check("mem_addr", mem_addr, exp_addr[cyc]);
            check("mem_valid_bit", 32'(mem_valid_bit), 32'(exp_vb[cyc]));
            if (exp_we[cyc]) check("mem_wdata", mem_wdata, exp_wdata[cyc]);
        end
        seen_if_done = if_done; seen_d_done = d_done;
        seen_if_err  = if_err;  seen_d_err  = d_err;
        seen_if_inst = if_inst; seen_d_rdata = d_rdata;
        seen_cyc = cyc;
        if (mem_ce) ce_cnt++;
        if (mem_we) begin
            we_cnt++;
            seen_wdata = mem_wdata;
        end
        if (mem_ce && mem_we)
            phys[mem_addr[7:2]] = merge(phys[mem_addr[7:2]], mem_addr[1:0], mem_valid_bit, mem_wdata);
        if (rec_order) begin
            if (d_done)  order.push_back(0);
            if (if_done) order.push_back(1);
        end
    endtask

    task automatic agents();
        if (seen_if_done) begin
            if (cont_mode) if_addr = 32'($urandom_range(0, 63) * 4);
            else if_req = 0;
        end
        if (seen_d_done) begin
            if (cont_mode) d_addr = 32'($urandom_range(0, 63) * 4);
            else d_req = 0;
        end
        if (rand_mode) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1;
                if_addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 255))
                                                      : 32'($urandom_range(0, 63) * 4);
            end else if (if_req && $urandom_range(0, 39) == 0) begin
                if_req = 0;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req       = 1;
                d_we        = 1'($urandom_range(0, 1));
                d_valid_bit = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                d_addr      = 32'($urandom_range(0, 255));
                d_wdata     = $urandom;
            end else if (d_req && $urandom_range(0, 39) == 0) begin
                d_req = 0;
            end
        end
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic tick();
        compare();
        agents();
        #1;
        check("if_stall_req", 32'(if_stall_req), 32'(if_req & ~exp_ifd[cyc]));
        check("d_stall_req",  32'(d_stall_req),  32'(d_req & ~exp_dd[cyc]));
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_done(input bit want_if, input int start, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (want_if ? seen_if_done : seen_d_done) begin
                lat = seen_cyc - start;
                break;
            end
        end
        if (lat < 0) check(want_if ? "if_done timeout" : "d_done timeout", 32'h0, 32'h1);
    endtask

    task automatic do_fetch(input logic [31:0] a, output int lat);
        int start;
        start = cyc; ce_cnt = 0; we_cnt = 0;
        if_req = 1; if_addr = a;
        run_until_done(1, start, lat);
    endtask

    task automatic do_data(input bit we, input logic [31:0] a, input logic [1:0] vb,
                           input logic [31:0] wd, output int lat);
        int start;
        start = cyc; ce_cnt = 0; we_cnt = 0;
        d_req = 1; d_we = we; d_addr = a; d_valid_bit = vb; d_wdata = wd;
        run_until_done(0, start, lat);
    endtask

    task automatic reset_mid();
        rst = 0;
        #1;
        check("mem_ce drops at async reset", 32'(mem_ce), 32'h0);
        check("if_done at async reset", 32'(if_done), 32'h0);
        check("d_done at async reset",  32'(d_done),  32'h0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1;
        clear_from(cyc - 1);
        free_at = cyc; starve = 0;
        mdl_if_inst = '0; mdl_d_rdata = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        for (int i = 0; i < 64; i++) begin
            phys[i]    = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            mdl_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end
        phys[4]    = 32'h00C0_0093;
        mdl_mem[4] = 32'h00C0_0093;
        clear_from(0);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset mem_ce",  32'(mem_ce),  32'h0);
        check("reset if_done", 32'(if_done), 32'h0);
        check("reset d_done",  32'(d_done),  32'h0);
        check("reset if_inst", if_inst, 32'h0);
        check("reset d_rdata", d_rdata, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        rst = 1;

        // Both requesters held from the first cycle out of reset.
        cont_mode = 1; rec_order = 1;
        if_req = 1; if_addr = 32'h40;
        d_req = 1; d_we = 0; d_valid_bit = 2'b11; d_addr = 32'h80;
        for (int i = 0; i < 80 && order.size() < 8; i++) tick();
        cont_mode = 0; rec_order = 0;
        if_req = 0; d_req = 0;
        if (order.size() < 8) check("grant order length", 32'(order.size()), 32'd8);
        else for (int i = 0; i < 8; i++)
            check($sformatf("grant order %0d", i), 32'(order[i]), 32'(exp_order[i]));
        repeat (8) tick();

        do_fetch(32'h10, lat);
        check("fetch 0x10 latency", 32'(lat), 32'd3);
        check("fetch 0x10 inst", seen_if_inst, 32'h00C0_0093);
        check("fetch 0x10 mem_ce cycles", 32'(ce_cnt), 32'd2);
        tick();

        do_data(1, 32'h10, 2'b11, 32'hAABB_CCDD, lat);
        check("store 0x10 latency", 32'(lat), 32'd3);
        check("store 0x10 mem_we cycles", 32'(we_cnt), 32'd2);
        check("store returns zero", seen_d_rdata, 32'h0);
        tick();
        do_data(0, 32'h13, 2'b01, 32'h0, lat);
        check("byte load 0x13", seen_d_rdata, 32'h0000_00AA);
        tick();
        do_data(0, 32'h12, 2'b10, 32'h0, lat);
        check("half load 0x12", seen_d_rdata, 32'h0000_AABB);
        tick();
        do_data(0, 32'h10, 2'b01, 32'h0, lat);
        check("byte load 0x10", seen_d_rdata, 32'h0000_00DD);
        tick();

        do_data(1, 32'h20, 2'b11, 32'h1234_5678, lat);
        check("store 0x20 mem_we cycles", 32'(we_cnt), 32'd2);
        check("store 0x20 mem_wdata", seen_wdata, 32'h1234_5678);
        tick();
        do_fetch(32'h20, lat);
        check("fetch after store", seen_if_inst, 32'h1234_5678);
        tick();

        do_data(0, 32'h22, 2'b11, 32'h0, lat);
        check("misaligned word latency", 32'(lat), 32'd1);
        check("misaligned word d_err", 32'(seen_d_err), 32'h1);
        check("misaligned word no mem_ce", 32'(ce_cnt), 32'h0);
        tick();
        do_fetch(32'h06, lat);
        check("misaligned fetch if_err", 32'(seen_if_err), 32'h1);
        check("misaligned fetch latency", 32'(lat), 32'd1);
        tick();
        do_data(0, 32'h20, 2'b00, 32'h0, lat);
        check("illegal size d_err", 32'(seen_d_err), 32'h1);
        check("illegal size no mem_ce", 32'(ce_cnt), 32'h0);
        tick();

        // Reset asserted between clock edges in the middle of a fetch.
        if_req = 1; if_addr = 32'h20;
        tick();
        tick();
        check("mem_ce high before reset", 32'(mem_ce), 32'h1);
        reset_mid();
        do_fetch(32'h20, lat);
        check("fetch after reset latency", 32'(lat), 32'd3);
        check("fetch after reset inst", seen_if_inst, 32'h1234_5678);
        tick();

        // Randomized traffic.
        rand_mode = 1;
        repeat (2000) tick();
        rand_mode = 0;
        if_req = 0; d_req = 0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
